add_accumulator: RTL and testbench
==================================

Name: add_accumulator

Overview:
- Sequencing stage wrapped around the 8-bit combinational adder.
- Presents operands on `add_a`/`add_b` and consumes the adder's `add_r`/`add_cout`.
- Extends the adder's result to a 16-bit running sum over a byte stream framed by `in_last`.
- Returns the packet sum, byte count and overflow flag to the downstream writeback over a valid/ready handshake.

Parameters:
- `MAX_BYTES`, default 255: maximum bytes per packet. The packet auto-closes when the count reaches this value. Legal range 1..255.

Ports:
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `in_valid`  input  1  input byte valid
- `in_ready`  output  1  block can accept a byte
- `in_data`  input  8  operand byte
- `in_last`  input  1  final byte of packet, qualified by `in_valid`
- `add_a`  output  8  to adder a: accumulator low byte
- `add_b`  output  8  to adder b: equals `in_data`
- `add_r`  input  8  from adder r
- `add_cout`  input  1  from adder cout
- `out_valid`  output  1  result valid
- `out_ready`  input  1  downstream accepts result
- `out_sum`  output  16  packet sum
- `out_count`  output  8  bytes accumulated in packet
- `out_ovf`  output  1  sum exceeded 16'hFFFF

Behaviour:
- Reset (async assert, sync deassert is handled upstream):
  - state = IDLE; `acc_lo` = 0, `acc_hi` = 0, `count` = 0, `ovf` = 0.
  - `out_valid` = 0, `in_ready` = 1; `out_sum` = 0, `out_count` = 0, `out_ovf` = 0.
- Adder interface (purely combinational): `add_a` = `acc_lo`, `add_b` = `in_data`. Adder result is used in the same cycle; no registering on the adder path.
- Byte accept: `in_valid && in_ready` on a rising edge. On accept:
  - `acc_lo` <= `add_r`
  - `acc_hi` <= `acc_hi` + `add_cout`
  - `count` <= `count` + 1
  - If `acc_hi` == 8'hFF and `add_cout` == 1, `ovf` <= 1 (sticky until packet drained).
- States:
  - IDLE:
    - `in_ready` = 1.
    - Accept with `in_last` = 0 and `count`+1 < `MAX_BYTES` -> ACC.
    - Accept with `in_last` = 1 or `count`+1 == `MAX_BYTES` -> DONE.
  - ACC:
    - `in_ready` = 1; same accept rules as IDLE.
    - Exits to DONE on `in_last` or `count` reaching `MAX_BYTES`.
  - DONE:
    - `in_ready` = 0; `out_valid` = 1.
    - `out_sum` = {`acc_hi`, `acc_lo`}, `out_count` = `count`, `out_ovf` = `ovf`.
    - Outputs are held stable while `out_ready` = 0.
    - On `out_ready` = 1: clear `acc_lo`, `acc_hi`, `count`, `ovf`; -> IDLE.
    - The cycle after drain, `in_ready` = 1 again (one bubble per packet).
- Latency: result valid the cycle after the accepting edge of the final byte.
- Wrap-around: without the optional feature, the 16-bit sum wraps modulo 65536. `out_ovf` reports the wrap.
- `in_valid` without `in_ready`: data is ignored. Upstream must hold the byte until `in_ready`.
- `MAX_BYTES` == 1: every accepted byte goes directly to DONE.
- Simultaneous `in_last` and the `MAX_BYTES` limit: a single DONE; no double close.
- Reset mid-packet or in DONE: everything clears immediately and the pending result is lost; `out_valid` drops asynchronously.
- `out_ready` outside DONE: ignored.

Optional Feature:
- Macro: `ADD_ACC_SAT_EN`.
- Defined:
  - When the overflow condition occurs, `acc_hi` and `acc_lo` are forced to 8'hFF.
  - Subsequent bytes in the packet leave the sum at 16'hFFFF; `count` still increments.
  - `out_ovf` is still set.
- Undefined: modulo-65536 wrap as above; no saturation logic is synthesised.

Test Plan:
1. Reset, then bytes 8'h10, 8'h20, 8'h30 (last) with `out_ready` = 1 -> `out_valid` one cycle after the third accept; `out_sum` = 16'h0060, `out_count` = 3, `out_ovf` = 0. Check `add_a` = 8'h00, 8'h10, 8'h30 on the successive accepts.
2. Carry chain: bytes 8'hFF, 8'h01, 8'hFF (last) -> `out_sum` = 16'h01FF, `out_count` = 3; `add_cout` = 1 observed on the second byte.
3. Backpressure: complete a packet with `out_ready` = 0 for 5 cycles while `in_valid` = 1 -> `in_ready` = 0 and outputs stable throughout. Raise `out_ready` -> IDLE next cycle; the next packet starts with sum 0.
4. Overflow: 258 packets' worth is impractical, so use `MAX_BYTES` = 255 and 255 bytes of 8'hFF followed by a second packet. Also preload via 2 packets: 255×8'hFF gives `out_sum` = 16'hFE01, `out_count` = 255, auto-close without `in_last`, `out_ovf` = 0. Then a dedicated long-packet test with `MAX_BYTES` = 255 and 8'hFF ×255 plus a force-stuck 8'hFF high byte via `$deposit` -> wrap with `out_ovf` = 1; with `ADD_ACC_SAT_EN`, `out_sum` = 16'hFFFF.
5. Async reset asserted mid-packet after 2 bytes (`rst_n` low between clock edges) -> `in_ready` = 1 and `out_valid` = 0 immediately. A following packet of 8'h05 (last) gives `out_sum` = 16'h0005, `out_count` = 1.
6. `MAX_BYTES` = 1: stream 8'h07, 8'h09 with `in_last` = 0 -> two separate results: 16'h0007 count 1, then 16'h0009 count 1.

Source files
------------

// File: rtl/add_accumulator_if.sv
// Byte-stream input handshake and packet-result output handshake of add_accumulator.
interface add_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/add_accumulator.sv
// 16-bit packet sum built around an external 8-bit adder; result valid 1 cycle after the last byte,
// in_ready held low until out_ready drains it. ADD_ACC_SAT_EN saturates the sum at 16'hFFFF on overflow.
module add_accumulator #(
  parameter int unsigned MAX_BYTES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  add_accumulator_if.slave bus,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [7:0]       add_r,
  input  logic             add_cout
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t     state;
  logic [7:0] acc_lo;
  logic [7:0] acc_hi;
  logic [7:0] count;
  logic       ovf;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       accept;
  logic       close;
  logic       wrap;
  logic [8:0] count_nxt;

  assign add_a     = acc_lo;
  assign add_b     = bus.in_data;
  assign accept    = bus.in_valid && in_ready_q;
  assign count_nxt = {1'b0, count} + 9'd1;
  // in_last and the byte limit landing together still yield one close
  assign close     = bus.in_last || (count_nxt == 9'(MAX_BYTES));
  assign wrap      = (acc_hi == 8'hFF) && add_cout;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = {acc_hi, acc_lo};
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_lo      <= 8'h00;
      acc_hi      <= 8'h00;
      count       <= 8'h00;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            count <= count_nxt[7:0];
            if (wrap) ovf <= 1'b1;
`ifdef ADD_ACC_SAT_EN
            if (wrap || ovf) begin
              acc_lo <= 8'hFF;
              acc_hi <= 8'hFF;
            end else begin
              acc_lo <= add_r;
              acc_hi <= acc_hi + {7'd0, add_cout};
            end
`else
            acc_lo <= add_r;
            acc_hi <= acc_hi + {7'd0, add_cout};
`endif
            if (close) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          // result stays frozen until the writeback takes it
          if (bus.out_ready) begin
            state       <= IDLE;
            acc_lo      <= 8'h00;
            acc_hi      <= 8'h00;
            count       <= 8'h00;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench for add_accumulator: one instance at MAX_BYTES=255, one at MAX_BYTES=1.
module tb_add_accumulator;
  logic clk;
  logic rst_n;
  logic sel;

  add_accumulator_if b0();
  add_accumulator_if b1();

  logic [7:0] a0, bb0, r0, a1, bb1, r1;
  logic       c0, c1;

  // external 8-bit adders
  assign {c0, r0} = {1'b0, a0} + {1'b0, bb0};
  assign {c1, r1} = {1'b0, a1} + {1'b0, bb1};

  add_accumulator #(.MAX_BYTES(255)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave),
    .add_a(a0), .add_b(bb0), .add_r(r0), .add_cout(c0)
  );

  add_accumulator #(.MAX_BYTES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave),
    .add_a(a1), .add_b(bb1), .add_r(r1), .add_cout(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_in_ready, s_out_valid, s_out_ovf, s_add_cout;
  logic [15:0] s_out_sum;
  logic [7:0]  s_out_count, s_add_a;

  assign s_in_ready  = sel ? b1.in_ready  : b0.in_ready;
  assign s_out_valid = sel ? b1.out_valid : b0.out_valid;
  assign s_out_sum   = sel ? b1.out_sum   : b0.out_sum;
  assign s_out_count = sel ? b1.out_count : b0.out_count;
  assign s_out_ovf   = sel ? b1.out_ovf   : b0.out_ovf;
  assign s_add_a     = sel ? a1 : a0;
  assign s_add_cout  = sel ? c1 : c0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] a_seen;
  logic       c_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      b1.in_valid = v; b1.in_data = d; b1.in_last = l;
    end else begin
      b0.in_valid = v; b0.in_data = d; b0.in_last = l;
    end
  endtask

  task automatic set_ordy(input logic r);
    if (sel) b1.out_ready = r;
    else     b0.out_ready = r;
  endtask

  // called just after a falling edge; returns just after the next falling edge
  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    drive(1'b1, d, l);
    while (!s_in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("in_ready_wait", 32'(s_in_ready), 32'd1);
    a_seen = s_add_a;
    c_seen = s_add_cout;
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic get(input string tag, input logic [15:0] sum, input logic [7:0] cnt, input logic ov);
    check({tag, "_valid"}, 32'(s_out_valid), 32'd1);
    check({tag, "_sum"},   32'(s_out_sum),   32'(sum));
    check({tag, "_count"}, 32'(s_out_count), 32'(cnt));
    check({tag, "_ovf"},   32'(s_out_ovf),   32'(ov));
    set_ordy(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(1'b0);
    check({tag, "_drained_valid"}, 32'(s_out_valid), 32'd0);
    check({tag, "_drained_ready"}, 32'(s_in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel   = 1'b0;
    rst_n = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = 8'h00; b0.in_last = 1'b0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.in_last = 1'b0; b1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_in_ready",  32'(s_in_ready),  32'd1);
    check("rst_out_valid", 32'(s_out_valid), 32'd0);
    check("rst_out_sum",   32'(s_out_sum),   32'd0);
    check("rst_out_count", 32'(s_out_count), 32'd0);
    check("rst_out_ovf",   32'(s_out_ovf),   32'd0);

    // basic sum and adder operand sequencing
    send(8'h10, 1'b0); check("t1_add_a0", 32'(a_seen), 32'h00);
    send(8'h20, 1'b0); check("t1_add_a1", 32'(a_seen), 32'h10);
    send(8'h30, 1'b1); check("t1_add_a2", 32'(a_seen), 32'h30);
    get("t1", 16'h0060, 8'd3, 1'b0);

    // carry into the high byte
    send(8'hFF, 1'b0);
    send(8'h01, 1'b0); check("t2_cout", 32'(c_seen), 32'd1);
    send(8'hFF, 1'b1);
    get("t2", 16'h01FF, 8'd3, 1'b0);

    // result held under backpressure while upstream keeps offering a byte
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    drive(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t3_bp_in_ready",  32'(s_in_ready),  32'd0);
      check("t3_bp_out_valid", 32'(s_out_valid), 32'd1);
      check("t3_bp_out_sum",   32'(s_out_sum),   32'h0003);
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 1'b0);
    get("t3", 16'h0003, 8'd2, 1'b0);
    send(8'h04, 1'b1); check("t3_next_add_a", 32'(a_seen), 32'h00);
    get("t3n", 16'h0004, 8'd1, 1'b0);

    // auto-close at MAX_BYTES without in_last
    for (int i = 0; i < 255; i++) send(8'hFF, 1'b0);
    get("t4_max", 16'hFE01, 8'd255, 1'b0);

    // high byte preloaded to FF, then a carry overflows the 16-bit sum
    send(8'hFF, 1'b0);
    force u0.acc_hi = 8'hFF;
    #1;
    release u0.acc_hi;
    send(8'h01, 1'b1);
`ifdef ADD_ACC_SAT_EN
    get("t4_ovf", 16'hFFFF, 8'd2, 1'b1);
`else
    get("t4_ovf", 16'h0000, 8'd2, 1'b1);
`endif

    // async reset mid-packet
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_mid_in_ready",  32'(s_in_ready),  32'd1);
    check("t5_mid_out_valid", 32'(s_out_valid), 32'd0);
    check("t5_mid_out_sum",   32'(s_out_sum),   32'd0);
    check("t5_mid_out_count", 32'(s_out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // async reset while a result is pending
    send(8'h33, 1'b1);
    check("t5_done_valid", 32'(s_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_done_out_valid", 32'(s_out_valid), 32'd0);
    check("t5_done_in_ready",  32'(s_in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h05, 1'b1);
    get("t5", 16'h0005, 8'd1, 1'b0);

    // MAX_BYTES = 1 closes on every byte, once even with in_last
    sel = 1'b1;
    @(negedge clk);
    send(8'h07, 1'b0);
    get("t6a", 16'h0007, 8'd1, 1'b0);
    send(8'h09, 1'b0);
    get("t6b", 16'h0009, 8'd1, 1'b0);
    send(8'h03, 1'b1);
    get("t6c", 16'h0003, 8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
